// File: rtl/display_layer_ctrl.sv
// display_layer_ctrl: per-pixel compositor for the game display path.
// Arbitrates border, sabers and player/opponent boxes under a per-frame
// front/back priority, and runs a hit-flash FSM that recolours the border
// for a programmable number of frames.
// Optional build macro: SABER_LAYER_EN (sabers take part in compositing;
// when undefined the saber inputs are masked to transparent).
module display_layer_ctrl #(
    parameter int          FLASH_FRAMES     = 8,
    parameter int          FLASH_BLINKS     = 3,
    parameter logic [23:0] BORDER_COLOR     = 24'hFFFFFF,
    parameter logic [23:0] PLAYER_HIT_COLOR = 24'hFF0000,
    parameter logic [23:0] OPP_HIT_COLOR    = 24'h0000FF,
    parameter logic [23:0] DOUBLE_HIT_COLOR = 24'hFFFF00,
    parameter logic [23:0] BG_COLOR         = 24'h000000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        new_frame_in,
    input  logic        pixel_valid_in,
    input  logic        game_border_in,
    input  logic [23:0] player_box_in,
    input  logic [23:0] opponent_box_in,
    input  logic [23:0] player_saber_in,
    input  logic [23:0] opponent_saber_in,
    input  logic        player_front_req_in,
    input  logic        hit_player_in,
    input  logic        hit_opponent_in,
    output logic [23:0] pixel_out,
    output logic        pixel_valid_out,
    output logic        flash_active_out,
    output logic        front_is_player_out
);

`ifdef SABER_LAYER_EN
    localparam logic SABER_EN = 1'b1;
`else
    localparam logic SABER_EN = 1'b0;
`endif

    localparam int FCW = $clog2(FLASH_FRAMES + 1);
    localparam int BCW = $clog2(FLASH_BLINKS + 1);
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(FLASH_FRAMES - 1);
    localparam logic [BCW-1:0] BLINK_LAST = BCW'(FLASH_BLINKS - 1);
    localparam logic [23:0]    SABER_MASK = {24{SABER_EN}};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FLASH_ON  = 2'd1,
        FLASH_OFF = 2'd2
    } state_t;

    state_t         state_r;
    logic [FCW-1:0] frame_cnt_r;
    logic [BCW-1:0] blink_cnt_r;
    logic           pending_r;
    logic [1:0]     hit_type_r;      // {player, opponent}
    logic           flash_active_r;
    logic           front_r;
    logic           hit_any_s;

    // Stage 1 registers
    logic           valid_s1_r;
    logic           border_s1_r;
    logic [23:0]    border_color_s1_r;
    logic           front_s1_r;
    logic [23:0]    pbox_s1_r;
    logic [23:0]    obox_s1_r;
    logic [23:0]    psaber_s1_r;
    logic [23:0]    osaber_s1_r;

    // Stage 2 registers and combinational selection
    logic [23:0]    pixel_r;
    logic           valid_r;
    logic [23:0]    border_color_s;
    logic [23:0]    front_saber_s;
    logic [23:0]    back_saber_s;
    logic [23:0]    front_box_s;
    logic [23:0]    back_box_s;
    logic [23:0]    pixel_s;

    assign hit_any_s = hit_player_in | hit_opponent_in;

    // Hit-flash FSM, pending-hit capture and frame-aligned priority update
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r        <= IDLE;
            frame_cnt_r    <= '0;
            blink_cnt_r    <= '0;
            pending_r      <= 1'b0;
            hit_type_r     <= 2'b00;
            flash_active_r <= 1'b0;
            front_r        <= 1'b1;
        end else begin
            if (new_frame_in) begin
                front_r <= player_front_req_in;
            end
            case (state_r)
                IDLE: begin
                    if (pending_r) begin
                        if (new_frame_in) begin
                            state_r        <= FLASH_ON;
                            pending_r      <= 1'b0;
                            frame_cnt_r    <= '0;
                            blink_cnt_r    <= '0;
                            flash_active_r <= 1'b1;
                        end
                    end else if (hit_any_s) begin
                        pending_r  <= 1'b1;
                        hit_type_r <= {hit_player_in, hit_opponent_in};
                    end
                end
                FLASH_ON: begin
                    if (new_frame_in) begin
                        if (frame_cnt_r == FRAME_LAST) begin
                            state_r     <= FLASH_OFF;
                            frame_cnt_r <= '0;
                        end else begin
                            frame_cnt_r <= frame_cnt_r + 1'b1;
                        end
                    end
                end
                FLASH_OFF: begin
                    if (new_frame_in) begin
                        if (frame_cnt_r == FRAME_LAST) begin
                            frame_cnt_r <= '0;
                            blink_cnt_r <= blink_cnt_r + 1'b1;
                            if (blink_cnt_r == BLINK_LAST) begin
                                state_r        <= IDLE;
                                flash_active_r <= 1'b0;
                                // A hit on the returning frame edge starts the next flash.
                                if (hit_any_s) begin
                                    pending_r  <= 1'b1;
                                    hit_type_r <= {hit_player_in, hit_opponent_in};
                                end
                            end else begin
                                state_r <= FLASH_ON;
                            end
                        end else begin
                            frame_cnt_r <= frame_cnt_r + 1'b1;
                        end
                    end
                end
                default: begin
                    state_r        <= IDLE;
                    pending_r      <= 1'b0;
                    flash_active_r <= 1'b0;
                end
            endcase
        end
    end

    // Current border colour from the flash state and latched hit type
    always_comb begin
        border_color_s = BORDER_COLOR;
        case (state_r)
            FLASH_ON: begin
                case (hit_type_r)
                    2'b11:   border_color_s = DOUBLE_HIT_COLOR;
                    2'b10:   border_color_s = PLAYER_HIT_COLOR;
                    2'b01:   border_color_s = OPP_HIT_COLOR;
                    default: border_color_s = BORDER_COLOR;
                endcase
            end
            default: border_color_s = BORDER_COLOR;
        endcase
    end

    // Stage 1: register layer inputs together with border colour and priority
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_s1_r        <= 1'b0;
            border_s1_r       <= 1'b0;
            border_color_s1_r <= 24'h000000;
            front_s1_r        <= 1'b1;
            pbox_s1_r         <= 24'h000000;
            obox_s1_r         <= 24'h000000;
            psaber_s1_r       <= 24'h000000;
            osaber_s1_r       <= 24'h000000;
        end else begin
            valid_s1_r        <= pixel_valid_in;
            border_s1_r       <= game_border_in;
            border_color_s1_r <= border_color_s;
            front_s1_r        <= front_r;
            pbox_s1_r         <= player_box_in;
            obox_s1_r         <= opponent_box_in;
            psaber_s1_r       <= player_saber_in & SABER_MASK;
            osaber_s1_r       <= opponent_saber_in & SABER_MASK;
        end
    end

    // Priority select: border > front saber > back saber > front box > back box > BG
    always_comb begin
        front_saber_s = front_s1_r ? psaber_s1_r : osaber_s1_r;
        back_saber_s  = front_s1_r ? osaber_s1_r : psaber_s1_r;
        front_box_s   = front_s1_r ? pbox_s1_r   : obox_s1_r;
        back_box_s    = front_s1_r ? obox_s1_r   : pbox_s1_r;
        pixel_s       = BG_COLOR;
        if (!valid_s1_r) begin
            pixel_s = 24'h000000;
        end else if (border_s1_r) begin
            pixel_s = border_color_s1_r;
        end else if (front_saber_s != 24'h000000) begin
            pixel_s = front_saber_s;
        end else if (back_saber_s != 24'h000000) begin
            pixel_s = back_saber_s;
        end else if (front_box_s != 24'h000000) begin
            pixel_s = front_box_s;
        end else if (back_box_s != 24'h000000) begin
            pixel_s = back_box_s;
        end else begin
            pixel_s = BG_COLOR;
        end
    end

    // Stage 2: register the selected colour and its qualifier
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pixel_r <= 24'h000000;
            valid_r <= 1'b0;
        end else begin
            pixel_r <= pixel_s;
            valid_r <= valid_s1_r;
        end
    end

    assign pixel_out           = pixel_r;
    assign pixel_valid_out     = valid_r;
    assign flash_active_out    = flash_active_r;
    assign front_is_player_out = front_r;

endmodule

// File: tb/tb_display_layer_ctrl.sv
// Directed testbench for display_layer_ctrl (FLASH_FRAMES=2, FLASH_BLINKS=2).
module tb_display_layer_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        new_frame_in = 1'b0;
    logic        pixel_valid_in = 1'b0;
    logic        game_border_in = 1'b0;
    logic [23:0] player_box_in = 24'h0;
    logic [23:0] opponent_box_in = 24'h0;
    logic [23:0] player_saber_in = 24'h0;
    logic [23:0] opponent_saber_in = 24'h0;
    logic        player_front_req_in = 1'b1;
    logic        hit_player_in = 1'b0;
    logic        hit_opponent_in = 1'b0;
    logic [23:0] pixel_out;
    logic        pixel_valid_out;
    logic        flash_active_out;
    logic        front_is_player_out;

    int n_vec = 0;
    int n_err = 0;

    display_layer_ctrl #(
        .FLASH_FRAMES(2),
        .FLASH_BLINKS(2)
    ) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .new_frame_in        (new_frame_in),
        .pixel_valid_in      (pixel_valid_in),
        .game_border_in      (game_border_in),
        .player_box_in       (player_box_in),
        .opponent_box_in     (opponent_box_in),
        .player_saber_in     (player_saber_in),
        .opponent_saber_in   (opponent_saber_in),
        .player_front_req_in (player_front_req_in),
        .hit_player_in       (hit_player_in),
        .hit_opponent_in     (hit_opponent_in),
        .pixel_out           (pixel_out),
        .pixel_valid_out     (pixel_valid_out),
        .flash_active_out    (flash_active_out),
        .front_is_player_out (front_is_player_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_vec(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clear_layers();
        pixel_valid_in    = 1'b0;
        game_border_in    = 1'b0;
        player_box_in     = 24'h0;
        opponent_box_in   = 24'h0;
        player_saber_in   = 24'h0;
        opponent_saber_in = 24'h0;
    endtask

    task automatic frame_pulse(input logic hp, input logic ho);
        new_frame_in    = 1'b1;
        hit_player_in   = hp;
        hit_opponent_in = ho;
        tick();
        new_frame_in    = 1'b0;
        hit_player_in   = 1'b0;
        hit_opponent_in = 1'b0;
    endtask

    task automatic hit_pulse(input logic hp, input logic ho);
        hit_player_in   = hp;
        hit_opponent_in = ho;
        tick();
        hit_player_in   = 1'b0;
        hit_opponent_in = 1'b0;
    endtask

    // Single valid pixel, checked two cycles later
    task automatic pixel(input string tag, input logic brd, input logic [23:0] pb,
                         input logic [23:0] ob, input logic [23:0] ps,
                         input logic [23:0] os, input logic [23:0] exp);
        pixel_valid_in    = 1'b1;
        game_border_in    = brd;
        player_box_in     = pb;
        opponent_box_in   = ob;
        player_saber_in   = ps;
        opponent_saber_in = os;
        tick();
        clear_layers();
        tick();
        check_vec({tag, "_px"}, pixel_out, exp);
        check_vec({tag, "_vld"}, {23'h0, pixel_valid_out}, 24'h1);
    endtask

    logic [23:0] exp_s;

    initial begin
        // Reset state
        rst_in = 1'b1;
        tick();
        tick();
        check_vec("rst_px", pixel_out, 24'h0);
        check_vec("rst_vld", {23'h0, pixel_valid_out}, 24'h0);
        check_vec("rst_flash", {23'h0, flash_active_out}, 24'h0);
        check_vec("rst_front", {23'h0, front_is_player_out}, 24'h1);
        rst_in = 1'b0;
        tick();

        // Test 1: two-cycle latency, player box in front
        pixel_valid_in  = 1'b1;
        player_box_in   = 24'h00FF00;
        opponent_box_in = 24'h112233;
        tick();
        clear_layers();
        check_vec("lat1_vld", {23'h0, pixel_valid_out}, 24'h0);
        check_vec("lat1_px", pixel_out, 24'h0);
        tick();
        check_vec("lat2_px", pixel_out, 24'h00FF00);
        check_vec("lat2_vld", {23'h0, pixel_valid_out}, 24'h1);
        tick();
        check_vec("lat3_vld", {23'h0, pixel_valid_out}, 24'h0);
        pixel("bg", 1'b0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h000000);

        // Test 2: priority change waits for the frame edge
        player_front_req_in = 1'b0;
        tick();
        check_vec("midf_front", {23'h0, front_is_player_out}, 24'h1);
        pixel("midf", 1'b0, 24'h00FF00, 24'h112233, 24'h0, 24'h0, 24'h00FF00);
        frame_pulse(1'b0, 1'b0);
        check_vec("nf_front", {23'h0, front_is_player_out}, 24'h0);
        pixel("opp_front", 1'b0, 24'h00FF00, 24'h112233, 24'h0, 24'h0, 24'h112233);
        player_front_req_in = 1'b1;
        frame_pulse(1'b0, 1'b0);
        check_vec("back_front", {23'h0, front_is_player_out}, 24'h1);

        // Test 3: player hit flash, 2 frames per phase, 2 blinks
        hit_pulse(1'b1, 1'b0);
        check_vec("pend_flash", {23'h0, flash_active_out}, 24'h0);
        pixel("pend_brd", 1'b1, 24'h0, 24'h0, 24'h0, 24'h0, 24'hFFFFFF);
        for (int k = 1; k <= 8; k++) begin
            frame_pulse(1'b0, 1'b0);
            check_vec($sformatf("p_f%0d_act", k), {23'h0, flash_active_out}, 24'h1);
            exp_s = (((k - 1) % 4) < 2) ? 24'hFF0000 : 24'hFFFFFF;
            pixel($sformatf("p_f%0d", k), 1'b1, 24'h0, 24'h0, 24'h0, 24'h0, exp_s);
        end
        frame_pulse(1'b0, 1'b0);
        check_vec("p_f9_act", {23'h0, flash_active_out}, 24'h0);
        pixel("p_f9", 1'b1, 24'h0, 24'h0, 24'h0, 24'h0, 24'hFFFFFF);

        // Test 4: simultaneous hit; a second hit mid-flash is ignored
        hit_pulse(1'b1, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            frame_pulse(1'b0, 1'b0);
            check_vec($sformatf("d_f%0d_act", k), {23'h0, flash_active_out}, 24'h1);
            exp_s = (((k - 1) % 4) < 2) ? 24'hFFFF00 : 24'hFFFFFF;
            pixel($sformatf("d_f%0d", k), 1'b1, 24'h0, 24'h0, 24'h0, 24'h0, exp_s);
            if (k == 2) begin
                hit_pulse(1'b1, 1'b0);
            end
        end
        frame_pulse(1'b0, 1'b0);
        check_vec("d_f9_act", {23'h0, flash_active_out}, 24'h0);
        frame_pulse(1'b0, 1'b0);
        check_vec("d_f10_act", {23'h0, flash_active_out}, 24'h0);
        pixel("d_f10", 1'b1, 24'h0, 24'h0, 24'h0, 24'h0, 24'hFFFFFF);

        // Test 5: reset during FLASH_ON flushes pipeline and pending state
        hit_pulse(1'b0, 1'b1);
        frame_pulse(1'b0, 1'b0);
        check_vec("o_f1_act", {23'h0, flash_active_out}, 24'h1);
        pixel("o_f1", 1'b1, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0000FF);
        pixel_valid_in = 1'b1;
        game_border_in = 1'b1;
        tick();
        clear_layers();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check_vec("mrst_flash", {23'h0, flash_active_out}, 24'h0);
        check_vec("mrst_px", pixel_out, 24'h0);
        check_vec("mrst_vld", {23'h0, pixel_valid_out}, 24'h0);
        pixel("mrst_brd", 1'b1, 24'h0, 24'h0, 24'h0, 24'h0, 24'hFFFFFF);
        frame_pulse(1'b0, 1'b0);
        check_vec("mrst_nopend", {23'h0, flash_active_out}, 24'h0);

        // Hit coinciding with the frame edge that returns to IDLE
        hit_pulse(1'b1, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            frame_pulse(1'b0, 1'b0);
        end
        check_vec("c_f8_act", {23'h0, flash_active_out}, 24'h1);
        pixel("c_f8", 1'b1, 24'h0, 24'h0, 24'h0, 24'h0, 24'hFFFFFF);
        frame_pulse(1'b0, 1'b1);
        check_vec("c_f9_act", {23'h0, flash_active_out}, 24'h0);
        frame_pulse(1'b0, 1'b0);
        check_vec("c_f10_act", {23'h0, flash_active_out}, 24'h1);
        pixel("c_f10", 1'b1, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0000FF);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;

        // Test 6: saber layer (build dependent)
`ifdef SABER_LAYER_EN
        pixel("sab_front", 1'b0, 24'h0, 24'h112233, 24'hABCDEF, 24'h0, 24'hABCDEF);
        pixel("sab_back", 1'b0, 24'h00FF00, 24'h0, 24'h0, 24'h445566, 24'h445566);
`else
        pixel("sab_front", 1'b0, 24'h0, 24'h112233, 24'hABCDEF, 24'h0, 24'h112233);
        pixel("sab_back", 1'b0, 24'h00FF00, 24'h0, 24'h0, 24'h445566, 24'h00FF00);
`endif
        pixel("sab_brd", 1'b1, 24'h00FF00, 24'h112233, 24'hABCDEF, 24'h445566, 24'hFFFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
